trainer_self_test: RTL and testbench

- Built-in stimulus/check sequencer for the digital trainer gate block. It is the driving end of the trainer's a/b/sel interface.
- On `start`, it walks every (sel, a, b) vector, drives it to the gate block, and waits a settle time. It then samples `y` and compares it against an internal golden truth table.
- It reports pass/fail, an error count and the first failing vector.
- It sits beside the trainer core; a top-level mux selects external pins or these stim outputs.

---
 rtl/trainer_self_test.sv | 140 ++++++++++++++
 tb/tb_trainer_self_test.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/trainer_self_test.sv
`default_nettype none
// ============================================================================
//  Module      : trainer_self_test
//  Description : Built-in stimulus/check sequencer for the trainer gate block.
//                Walks every (sel, a, b) vector, waits a settle time, samples
//                the gate output and compares it with a golden truth table.
//                Reports pass/fail, a saturating error count and the first
//                failing vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module trainer_self_test #(
    parameter int NUM_SEL       = 7,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dut_y,
    output logic             stim_a,
    output logic             stim_b,
    output logic [2:0]       stim_sel,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [4:0]       first_fail_vec
);

    // Sequencer states
    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_DRIVE  = 3'd1;
    localparam logic [2:0] c_SETTLE = 3'd2;
    localparam logic [2:0] c_SAMPLE = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;

    // Settle counter runs 0..SETTLE_CYCLES-1; keep at least one bit wide
    localparam int                 c_CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam bit                 c_HAS_SETTLE  = (SETTLE_CYCLES > 0);

    // Vector index {sel, a, b}: incrementing it walks b fastest, then a, then sel
    localparam logic [4:0]       c_LAST_VEC = 5'(4 * NUM_SEL - 1);
    localparam logic [ERR_W-1:0] c_ERR_MAX  = '1;

    logic [2:0]         r_state;
    logic [4:0]         r_vec;
    logic [c_CNT_W-1:0] r_settle_cnt;
    logic [ERR_W-1:0]   r_err_count;
    logic               r_ff_valid;
    logic [4:0]         r_ff_vec;

    logic               w_golden;
    logic               w_mismatch;

    // Golden gate response for the vector currently being driven
    always_comb begin
        w_golden = 1'b0;
        case (r_vec[4:2])
            3'd0:    w_golden =   r_vec[1] & r_vec[0];
            3'd1:    w_golden =   r_vec[1] | r_vec[0];
            3'd2:    w_golden = ~(r_vec[1] & r_vec[0]);
            3'd3:    w_golden = ~(r_vec[1] | r_vec[0]);
            3'd4:    w_golden =   r_vec[1] ^ r_vec[0];
            3'd5:    w_golden = ~(r_vec[1] ^ r_vec[0]);
            3'd6:    w_golden =  ~r_vec[1];
            default: w_golden = 1'b0;
        endcase
    end

    assign w_mismatch = dut_y ^ w_golden;

    // Sequencer: state, vector walk, settle timing and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_vec        <= '0;
            r_settle_cnt <= '0;
            r_err_count  <= '0;
            r_ff_valid   <= 1'b0;
            r_ff_vec     <= '0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_state      <= c_DRIVE;
                        r_vec        <= '0;
                        r_settle_cnt <= '0;
                        r_err_count  <= '0;
                        r_ff_valid   <= 1'b0;
                        r_ff_vec     <= '0;
                    end
                end
                c_DRIVE: begin
                    r_settle_cnt <= '0;
                    r_state      <= c_HAS_SETTLE ? c_SETTLE : c_SAMPLE;
                end
                c_SETTLE: begin
                    if (r_settle_cnt == c_SETTLE_LAST) begin
                        r_state <= c_SAMPLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                c_SAMPLE: begin
                    if (w_mismatch) begin
                        if (r_err_count != c_ERR_MAX) begin
                            r_err_count <= r_err_count + 1'b1;
                        end
                        if (!r_ff_valid) begin
                            r_ff_valid <= 1'b1;
                            r_ff_vec   <= r_vec;
                        end
                    end
                    if (r_vec == c_LAST_VEC) begin
                        r_state <= c_DONE;
                        r_vec   <= '0;
                    end else begin
                        r_state <= c_DRIVE;
                        r_vec   <= r_vec + 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign stim_sel         = r_vec[4:2];
    assign stim_a           = r_vec[1];
    assign stim_b           = r_vec[0];
    assign busy             = (r_state == c_DRIVE) || (r_state == c_SETTLE) || (r_state == c_SAMPLE);
    assign done             = (r_state == c_DONE);
    assign pass             = done && (r_err_count == '0);
    assign err_count        = r_err_count;
    assign first_fail_valid = r_ff_valid;
    assign first_fail_vec   = r_ff_vec;

endmodule
`default_nettype wire

// File: tb/tb_trainer_self_test.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trainer_self_test
//  Description : Self-checking bench for trainer_self_test. A behavioural gate
//                model drives dut_y from the stimulus outputs with selectable
//                fault modes; results are compared with expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trainer_self_test;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       dut_y;
    logic       stim_a, stim_b;
    logic [2:0] stim_sel;
    logic       busy, done, pass;
    logic [4:0] err_count;
    logic       first_fail_valid;
    logic [4:0] first_fail_vec;

    // Narrow-counter instance: its gate output is stuck at 0
    logic       stim_a3, stim_b3;
    logic [2:0] stim_sel3;
    logic       busy3, done3, pass3;
    logic [2:0] err_count3;
    logic       ffv3;
    logic [4:0] ffvec3;

    int checks = 0;
    int errors = 0;

    int mode;          // 0 golden, 1 stuck0, 2 stuck1, 3 sel4 forced 0, 4 random flips
    bit flip [32];

    trainer_self_test dut (
        .clk(clk), .rst(rst), .start(start), .dut_y(dut_y),
        .stim_a(stim_a), .stim_b(stim_b), .stim_sel(stim_sel),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_valid(first_fail_valid), .first_fail_vec(first_fail_vec)
    );

    trainer_self_test #(.NUM_SEL(7), .SETTLE_CYCLES(2), .ERR_W(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .dut_y(1'b0),
        .stim_a(stim_a3), .stim_b(stim_b3), .stim_sel(stim_sel3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err_count3),
        .first_fail_valid(ffv3), .first_fail_vec(ffvec3)
    );

    always #5 clk = ~clk;

    // Truth table per gate, bit index = {a,b}
    function automatic logic [3:0] truth(input logic [2:0] sel);
        case (sel)
            3'd0:    return 4'b1000;
            3'd1:    return 4'b1110;
            3'd2:    return 4'b0111;
            3'd3:    return 4'b0001;
            3'd4:    return 4'b0110;
            3'd5:    return 4'b1001;
            3'd6:    return 4'b0011;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic gate(input logic [2:0] sel, input logic a, input logic b);
        logic [3:0] t;
        t = truth(sel);
        return t[{a, b}];
    endfunction

    // Behavioural gate block with fault injection
    always_comb begin
        dut_y = 1'b0;
        case (mode)
            0: dut_y = gate(stim_sel, stim_a, stim_b);
            1: dut_y = 1'b0;
            2: dut_y = 1'b1;
            3: dut_y = (stim_sel == 3'd4) ? 1'b0 : gate(stim_sel, stim_a, stim_b);
            4: dut_y = gate(stim_sel, stim_a, stim_b) ^ flip[{stim_sel, stim_a, stim_b}];
            default: dut_y = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {16'd0, stim_a, stim_b, stim_sel, busy, done, pass,
                   err_count, first_fail_valid, first_fail_vec}, 32'd0);
    endtask

    // Pulse start, follow the run; optionally re-pulse start or reset mid-run
    task automatic do_run(input int restart_at, input int rst_at, output bit completed);
        int busy_cnt;
        int lat;
        completed = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_done_clear", done, 0);
        chk("start_err_clear", err_count, 0);
        chk("start_ffv_clear", first_fail_valid, 0);
        busy_cnt = int'(busy);
        lat = -1;
        for (int k = 1; k <= 300; k++) begin
            if (k == restart_at) start = 1'b1;
            if (k == rst_at) rst = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (k == rst_at) begin
                rst = 1'b0;
                chk_all_zero("midrun_reset_outputs");
                return;
            end
            if (done) begin
                lat = k;
                break;
            end
            busy_cnt += int'(busy);
        end
        chk("done_latency", lat, 112);
        chk("busy_cycles", busy_cnt, 112);
        chk("stim_cleared", {stim_sel, stim_a, stim_b}, 0);
        chk("busy_low_done", busy, 0);
        chk("narrow_done_same_cycle", done3, 1);
        chk("narrow_err_saturated", err_count3, 7);
        completed = 1'b1;
    endtask

    task automatic chk_results(input string name, input int exp_err, input bit exp_ffv,
                               input logic [4:0] exp_vec);
        chk({name, "_err"}, err_count, exp_err);
        chk({name, "_ffv"}, first_fail_valid, exp_ffv);
        chk({name, "_ffvec"}, first_fail_vec, exp_vec);
        chk({name, "_pass"}, pass, (exp_err == 0) ? 1 : 0);
    endtask

    typedef struct {
        int         mode;
        int         exp_err;
        bit         exp_ffv;
        logic [4:0] exp_vec;
    } vec_t;

    initial begin
        vec_t tbl [4];
        bit   ok;
        int   n_err;
        int   first;

        tbl[0] = '{mode: 0, exp_err: 0,  exp_ffv: 1'b0, exp_vec: 5'b000_00};
        tbl[1] = '{mode: 1, exp_err: 14, exp_ffv: 1'b1, exp_vec: 5'b000_11};
        tbl[2] = '{mode: 2, exp_err: 14, exp_ffv: 1'b1, exp_vec: 5'b000_00};
        tbl[3] = '{mode: 3, exp_err: 2,  exp_ffv: 1'b1, exp_vec: 5'b100_01};

        rst = 1'b1;
        start = 1'b0;
        mode = 0;
        foreach (flip[i]) flip[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset_outputs");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("idle_hold");

        // Fixed fault patterns
        for (int i = 0; i < 4; i++) begin
            mode = tbl[i].mode;
            do_run(-1, -1, ok);
            chk_results($sformatf("table%0d", i), tbl[i].exp_err, tbl[i].exp_ffv, tbl[i].exp_vec);
        end

        // Results hold in DONE while start stays low
        repeat (5) @(posedge clk);
        #1;
        chk("done_hold", done, 1);
        chk("done_hold_err", err_count, 2);

        // Start during a run is ignored
        mode = 0;
        do_run(40, -1, ok);
        chk_results("restart_ignored", 0, 1'b0, 5'b0);

        // Reset mid-run discards partial results, then a fresh run completes
        mode = 1;
        do_run(-1, 60, ok);
        chk("reset_run_aborted", ok, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("post_reset_idle");
        mode = 0;
        do_run(-1, -1, ok);
        chk_results("after_reset_run", 0, 1'b0, 5'b0);

        // Random single-bit faults checked against a counted reference
        for (int it = 0; it < 6; it++) begin
            n_err = 0;
            first = -1;
            for (int v = 0; v < 32; v++) begin
                flip[v] = (v < 28) && ($urandom_range(0, 3) == 0);
                if (flip[v]) begin
                    n_err++;
                    if (first < 0) first = v;
                end
            end
            mode = 4;
            do_run(-1, -1, ok);
            chk_results($sformatf("random%0d", it), (n_err > 31) ? 31 : n_err,
                        (first >= 0), (first >= 0) ? 5'(first) : 5'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
